regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, data width of every register, write port and read port.
REQ-002 Parameter AW, default 5, register address width; the register count is NREG = 2**AW.
REQ-003 Parameter BYPASS, default 1; 1 = a write is forwarded to a same-cycle read of the same register, 0 = no forwarding.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port RegW, input, 1, write enable for the current cycle.
REQ-007 Port Rd, input, AW, write register index.
REQ-008 Port Wd, input, XLEN, write data.
REQ-009 Port Rs1, input, AW, read port 1 index.
REQ-010 Port Rs2, input, AW, read port 2 index.
REQ-011 Port rd1, output, XLEN, read port 1 data (combinational).
REQ-012 Port rd2, output, XLEN, read port 2 data (combinational).
REQ-013 Port Alloc, input, 1, issue of an instruction that will write register AllocRd.
REQ-014 Port AllocRd, input, AW, destination index being reserved.
REQ-015 Port Flush, input, 1, clears all pending reservations.
REQ-016 Port busy1, output, 1, register Rs1 has a pending write.
REQ-017 Port busy2, output, 1, register Rs2 has a pending write.
REQ-018 Port hazard, output, 1, busy1 OR busy2.
REQ-019 Port pend_cnt, output, AW+1, number of registers currently reserved.

Function
REQ-020 Register 0 SHALL always read 0; writes and reservations to index 0 SHALL be ignored.
REQ-021 When RegW=1 and Rd!=0, Registers[Rd] SHALL take Wd at the rising edge.
REQ-022 rd1/rd2 SHALL show Registers[Rs1]/Registers[Rs2] combinationally, with zero latency.
REQ-023 With BYPASS=1, rd1 SHALL show Wd when RegW=1 and Rd==Rs1!=0 in the same cycle; the same rule applies to rd2 with Rs2.
REQ-024 With BYPASS=0, a same-cycle read SHALL return the old value; the new value is visible from the next cycle.
REQ-025 The scoreboard SHALL be one pending bit per register; bit 0 SHALL be constant 0.
REQ-026 At the edge, Alloc=1 with AllocRd!=0 SHALL set pend[AllocRd].
REQ-027 At the edge, RegW=1 with Rd!=0 SHALL clear pend[Rd].
REQ-028 If an alloc and a writeback target the same register in the same cycle, the alloc SHALL win and the bit ends set.
REQ-029 Alloc to an already-pending register SHALL leave the bit set and SHALL NOT change pend_cnt.
REQ-030 Writeback to a non-pending register SHALL update the data only; pend_cnt SHALL stay unchanged.
REQ-031 Flush=1 SHALL clear all pending bits at the edge and override same-cycle alloc and clear; a same-cycle RegW SHALL still write the data.
REQ-032 busy1 SHALL equal pend[Rs1] and busy2 SHALL equal pend[Rs2], both combinational from the registered bits.
REQ-033 busy SHALL NOT be bypassed by a same-cycle writeback; it drops the cycle after the clear.
REQ-034 pend_cnt SHALL be a registered count equal to the population of the pend bits after every edge: +1 for a new set, -1 for a real clear, net 0 when both occur on different registers, 0 after a flush.
REQ-035 pend_cnt SHALL never exceed NREG-1 and SHALL never underflow.

Reset
REQ-036 While reset=0, all registers, all pend bits and pend_cnt SHALL be 0 immediately, without waiting for a clock edge.
REQ-037 While reset=0, writes, allocs and flushes SHALL be ignored; rd1/rd2 SHALL read 0 and busy1, busy2 and hazard SHALL be 0.
REQ-038 Reset asserted mid-operation SHALL discard all pending reservations; normal operation resumes on the first edge after reset=1.

Verification
REQ-039 Reset pulse, then read all indices -> every rd1/rd2 value = 0, pend_cnt = 0.
REQ-040 Write x5=0xDEADBEEF with Rs1=5 in the same cycle: BYPASS=1 -> rd1=0xDEADBEEF that cycle; BYPASS=0 -> rd1=0 that cycle and 0xDEADBEEF the next.
REQ-041 RegW=1, Rd=0, Wd=0xFFFFFFFF plus Alloc to x0 -> rd1 at Rs1=0 stays 0, busy1=0, pend_cnt=0.
REQ-042 Alloc x3 and x7, then Rs1=3, Rs2=7 -> busy1=busy2=hazard=1, pend_cnt=2; writeback x3 -> next cycle busy1=0, pend_cnt=1.
REQ-043 Same-cycle Alloc x4 and writeback x4 with x4 pending -> x4 holds the new data, busy stays 1, pend_cnt unchanged; then Flush together with Alloc x9 -> pend_cnt=0 and busy1/busy2 are 0 for all indices.
REQ-044 Allocate x1..x31, then assert reset=0 between edges -> pend_cnt reads 31 before reset and 0 immediately after reset=0, with no clock edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file (x0 hardwired to zero) with a one-bit-per-register pending-write
// scoreboard and a registered count of outstanding reservations.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegW,
    input  logic [AW-1:0]   Rd,
    input  logic [XLEN-1:0] Wd,
    input  logic [AW-1:0]   Rs1,
    input  logic [AW-1:0]   Rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            Alloc,
    input  logic [AW-1:0]   AllocRd,
    input  logic            Flush,
    output logic            busy1,
    output logic            busy2,
    output logic            hazard,
    output logic [AW:0]     pend_cnt
);
    localparam int NREG = 2**AW;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_next;
    logic            wb_v;
    logic            alloc_v;
    logic            set_new;
    logic            clr_real;

    assign wb_v    = RegW && (Rd != '0);
    assign alloc_v = Alloc && (AllocRd != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_v) begin
            regs[Rd] <= Wd;
        end
    end

    // Forwarding is suppressed during reset so reads stay at zero.
    always_comb begin
        rd1 = regs[Rs1];
        rd2 = regs[Rs2];
        if (BYPASS != 0 && reset && wb_v && Rd == Rs1) rd1 = Wd;
        if (BYPASS != 0 && reset && wb_v && Rd == Rs2) rd2 = Wd;
        if (Rs1 == '0) rd1 = '0;
        if (Rs2 == '0) rd2 = '0;
    end

    // Alloc is applied after the clear so it wins on a same-register collision.
    always_comb begin
        pend_next = pend;
        if (wb_v) pend_next[Rd] = 1'b0;
        if (alloc_v) pend_next[AllocRd] = 1'b1;
        pend_next[0] = 1'b0;
    end

    assign set_new  = alloc_v && !pend[AllocRd];
    assign clr_real = wb_v && pend[Rd] && !(alloc_v && AllocRd == Rd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else if (Flush) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_next;
            pend_cnt <= pend_cnt + (AW+1)'(set_new) - (AW+1)'(clr_real);
        end
    end

    assign busy1  = pend[Rs1];
    assign busy2  = pend[Rs2];
    assign hazard = busy1 | busy2;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: a BYPASS=1 and a BYPASS=0 instance share stimulus and are
// compared against a reference model through an expected-value queue.
`timescale 1ns/1ps
module tb_regfile_scoreboard;
    localparam int W = 146;

    logic        clk;
    logic        reset;
    logic        RegW;
    logic [4:0]  Rd;
    logic [31:0] Wd;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic        Alloc;
    logic [4:0]  AllocRd;
    logic        Flush;
    logic [31:0] rd1, rd2, rd1_n, rd2_n;
    logic        busy1, busy2, hazard, busy1_n, busy2_n, hazard_n;
    logic [5:0]  pend_cnt, pend_cnt_n;

    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic [W-1:0] exp_q[$];
    int checks;
    int errors;

    regfile_scoreboard #(.XLEN(32), .AW(5), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .RegW(RegW), .Rd(Rd), .Wd(Wd), .Rs1(Rs1), .Rs2(Rs2),
        .rd1(rd1), .rd2(rd2), .Alloc(Alloc), .AllocRd(AllocRd), .Flush(Flush),
        .busy1(busy1), .busy2(busy2), .hazard(hazard), .pend_cnt(pend_cnt)
    );

    regfile_scoreboard #(.XLEN(32), .AW(5), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .RegW(RegW), .Rd(Rd), .Wd(Wd), .Rs1(Rs1), .Rs2(Rs2),
        .rd1(rd1_n), .rd2(rd2_n), .Alloc(Alloc), .AllocRd(AllocRd), .Flush(Flush),
        .busy1(busy1_n), .busy2(busy2_n), .hazard(hazard_n), .pend_cnt(pend_cnt_n)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    function automatic logic [31:0] m_read(input logic [4:0] idx, input logic byp);
        if (!reset || idx == 5'd0) return 32'd0;
        if (byp && RegW && Rd == idx) return Wd;
        return m_regs[idx];
    endfunction

    function automatic logic [W-1:0] model_out();
        logic [31:0] a1, a2, b1, b2;
        logic        s1, s2;
        logic [5:0]  cnt;
        a1  = m_read(Rs1, 1'b1);
        a2  = m_read(Rs2, 1'b1);
        b1  = m_read(Rs1, 1'b0);
        b2  = m_read(Rs2, 1'b0);
        s1  = m_pend[Rs1];
        s2  = m_pend[Rs2];
        cnt = 6'($countones(m_pend));
        return {a1, a2, s1, s2, s1 | s2, cnt, b1, b2, s1, s2, s1 | s2, cnt};
    endfunction

    function automatic logic [W-1:0] dut_out();
        return {rd1, rd2, busy1, busy2, hazard, pend_cnt,
                rd1_n, rd2_n, busy1_n, busy2_n, hazard_n, pend_cnt_n};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pend = 32'd0;
    endtask

    task automatic model_edge();
        if (RegW && Rd != 5'd0) m_regs[Rd] = Wd;
        if (Flush) begin
            m_pend = 32'd0;
        end else begin
            if (RegW && Rd != 5'd0) m_pend[Rd] = 1'b0;
            if (Alloc && AllocRd != 5'd0) m_pend[AllocRd] = 1'b1;
        end
    endtask

    // driver tasks
    task automatic drive(input logic regw, input logic [4:0] rd, input logic [31:0] wd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic alloc, input logic [4:0] allocrd, input logic flush);
        RegW = regw; Rd = rd; Wd = wd; Rs1 = rs1; Rs2 = rs2;
        Alloc = alloc; AllocRd = allocrd; Flush = flush;
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_edge();
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] got, exp;
        drive(1'b1, 5'd5, 32'h1111_2222, 5'd5, 5'd3, 1'b1, 5'd3, 1'b0);
        exp_q.push_back(model_out());
        @(negedge clk);
        got = dut_out(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_hold got=%h exp=%h", got, exp); end
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0, 5'd0, 1'b0);
            exp_q.push_back(model_out());
            @(negedge clk);
            got = dut_out(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_read idx=%0d got=%h exp=%h", i, got, exp); end
            step();
        end
    endtask

    task automatic test_x0();
        logic [W-1:0] got, exp;
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        exp_q.push_back(model_out());
        @(negedge clk);
        got = dut_out(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL x0_same got=%h exp=%h", got, exp); end
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (rd1 !== 32'd0 || busy1 !== 1'b0 || pend_cnt !== 6'd0) begin
            errors++;
            $display("FAIL x0_after rd1=%h busy1=%b cnt=%0d exp 0/0/0", rd1, busy1, pend_cnt);
        end
        step();
    endtask

    task automatic test_bypass();
        logic [W-1:0] got, exp;
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
        exp_q.push_back(model_out());
        @(negedge clk);
        got = dut_out(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL bypass_same got=%h exp=%h", got, exp); end
        checks++;
        if (rd1 !== 32'hDEAD_BEEF || rd1_n !== 32'd0) begin
            errors++;
            $display("FAIL bypass_values rd1=%h rd1_n=%h exp deadbeef/0", rd1, rd1_n);
        end
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (rd1 !== 32'hDEAD_BEEF || rd1_n !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass_next rd1=%h rd1_n=%h exp deadbeef", rd1, rd1_n);
        end
        step();
    endtask

    task automatic test_alloc_busy();
        logic [W-1:0] got, exp;
        drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd7, 1'b1, 5'd3, 1'b0);
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0);
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd7, 1'b0, 5'd0, 1'b0);
        exp_q.push_back(model_out());
        @(negedge clk);
        got = dut_out(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL alloc_two got=%h exp=%h", got, exp); end
        checks++;
        if ({busy1, busy2, hazard} !== 3'b111 || pend_cnt !== 6'd2) begin
            errors++;
            $display("FAIL alloc_two_vals busy=%b%b%b cnt=%0d exp 111/2", busy1, busy2, hazard, pend_cnt);
        end
        step();
        // busy must not drop in the writeback cycle itself
        drive(1'b1, 5'd3, 32'h0000_0333, 5'd3, 5'd7, 1'b0, 5'd0, 1'b0);
        exp_q.push_back(model_out());
        @(negedge clk);
        got = dut_out(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL wb_same_cycle got=%h exp=%h", got, exp); end
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd7, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || pend_cnt !== 6'd1 || rd1 !== 32'h0000_0333) begin
            errors++;
            $display("FAIL wb_next busy1=%b cnt=%0d rd1=%h exp 0/1/333", busy1, pend_cnt, rd1);
        end
        step();
    endtask

    task automatic test_alloc_wb_same();
        logic [W-1:0] got, exp;
        drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0);
        step();
        drive(1'b1, 5'd4, 32'h1234_5678, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0);
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd4, 5'd7, 1'b0, 5'd0, 1'b0);
        exp_q.push_back(model_out());
        @(negedge clk);
        got = dut_out(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL alloc_wins got=%h exp=%h", got, exp); end
        checks++;
        if (rd1 !== 32'h1234_5678 || busy1 !== 1'b1 || pend_cnt !== 6'd2) begin
            errors++;
            $display("FAIL alloc_wins_vals rd1=%h busy1=%b cnt=%0d exp 12345678/1/2", rd1, busy1, pend_cnt);
        end
        step();
        // flush overrides alloc but the data write still lands
        drive(1'b1, 5'd10, 32'h0000_A5A5, 5'd9, 5'd10, 1'b1, 5'd9, 1'b1);
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd10, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (pend_cnt !== 6'd0 || rd2 !== 32'h0000_A5A5) begin
            errors++;
            $display("FAIL flush cnt=%0d rd2=%h exp 0/a5a5", pend_cnt, rd2);
        end
        step();
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0, 5'd0, 1'b0);
            exp_q.push_back(model_out());
            @(negedge clk);
            got = dut_out(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL flush_scan idx=%0d got=%h exp=%h", i, got, exp); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got, exp;
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 15) == 0));
            exp_q.push_back(model_out());
            @(negedge clk);
            got = dut_out(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL random n=%0d got=%h exp=%h", n, got, exp); end
            step();
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] got, exp;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        step();
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd31, 1'b1, 5'(i), 1'b0);
            step();
        end
        drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd31, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (pend_cnt !== 6'd31 || hazard !== 1'b1) begin
            errors++;
            $display("FAIL full_alloc cnt=%0d hazard=%b exp 31/1", pend_cnt, hazard);
        end
        #1;
        reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if (pend_cnt !== 6'd0 || busy1 !== 1'b0 || busy2 !== 1'b0 || hazard !== 1'b0) begin
            errors++;
            $display("FAIL async_reset cnt=%0d busy=%b%b%b exp 0/000", pend_cnt, busy1, busy2, hazard);
        end
        step();
        drive(1'b1, 5'd5, 32'h5555_5555, 5'd5, 5'd6, 1'b1, 5'd6, 1'b1);
        exp_q.push_back(model_out());
        @(negedge clk);
        got = dut_out(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_ignore got=%h exp=%h", got, exp); end
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd6, 5'd5, 1'b1, 5'd6, 1'b0);
        reset = 1'b1;
        step();
        drive(1'b0, 5'd0, 32'd0, 5'd6, 5'd5, 1'b0, 5'd0, 1'b0);
        exp_q.push_back(model_out());
        @(negedge clk);
        got = dut_out(); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL resume got=%h exp=%h", got, exp); end
        checks++;
        if (busy1 !== 1'b1 || pend_cnt !== 6'd1 || rd2 !== 32'd0) begin
            errors++;
            $display("FAIL resume_vals busy1=%b cnt=%0d rd2=%h exp 1/1/0", busy1, pend_cnt, rd2);
        end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        model_clear();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_x0();
        test_bypass();
        test_alloc_busy();
        test_alloc_wb_same();
        test_back_to_back();
        test_async_reset();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left=%0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
